// File: rtl/ula_seq_if.sv
// Bundle of producer, ula and consumer signals around ula_seq.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface ula_seq_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_op;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         in_chain;
   logic [2:0]   ula_op;
   logic [N-1:0] ula_a;
   logic [N-1:0] ula_b;
   logic [N-1:0] ula_r;
   logic         ula_zero;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_r;
   logic         out_zero;
   logic [2:0]   out_op;
   logic [N-1:0] acc;
   logic         busy;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_chain, ula_r, ula_zero, out_ready,
      output in_ready, ula_op, ula_a, ula_b, out_valid, out_r, out_zero, out_op, acc, busy
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_chain, ula_r, ula_zero, out_ready,
      input  in_ready, ula_op, ula_a, ula_b, out_valid, out_r, out_zero, out_op, acc, busy
   );
endinterface

// File: rtl/ula_seq.sv
// Command sequencer: FIFO of ALU commands issued one per cycle to an external
// combinational ula, with a registered result stage and a chain accumulator.
module ula_seq #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input logic      clk,
   input logic      rst,
   ula_seq_if.slave bus
);
   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         chain;
   } cmd_t;

   typedef enum logic {S_IDLE, S_FULL} state_t;

   cmd_t          r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   state_t        r_state;
   logic [N-1:0]  r_out_r;
   logic          r_out_zero;
   logic [2:0]    r_out_op;
   logic [N-1:0]  r_acc;

   cmd_t w_head;
   logic w_out_valid;
   logic w_push;
   logic w_issue;

   assign w_head      = r_mem[r_rd_ptr];
   assign w_out_valid = (r_state == S_FULL);
   // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
   assign bus.in_ready = !rst && (r_count < FULL_CNT);
   assign w_push       = bus.in_valid && bus.in_ready;
   assign w_issue      = (r_count != '0) && (!w_out_valid || bus.out_ready);

   assign bus.ula_op = w_head.op;
   assign bus.ula_a  = w_head.chain ? r_acc : w_head.a;
   assign bus.ula_b  = w_head.b;

   assign bus.out_valid = w_out_valid;
   assign bus.out_r     = r_out_r;
   assign bus.out_zero  = r_out_zero;
   assign bus.out_op    = r_out_op;
   assign bus.acc       = r_acc;
   assign bus.busy      = (r_count != '0) || w_out_valid;

   // FIFO storage is never cleared; only the pointers and count are reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b, chain: bus.in_chain};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_issue) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_issue) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Output stage: issue only happens when the register is free or being drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_out_r    <= '0;
         r_out_zero <= 1'b0;
         r_out_op   <= 3'b000;
         r_acc      <= '0;
      end else begin
         if (w_issue) begin
            r_out_r    <= bus.ula_r;
            r_out_zero <= bus.ula_zero;
            r_out_op   <= w_head.op;
            r_acc      <= bus.ula_r;
         end
         case (r_state)
            S_IDLE: if (w_issue) r_state <= S_FULL;
            S_FULL: if (bus.out_ready && !w_issue) r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: directed scenarios plus a randomized run
// against a queue-level reference model; the ula itself is modelled here.
module tb_ula_seq;
   localparam int N     = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ula_seq_if #(.N(N)) bus ();

   ula_seq #(.N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [N-1:0] alu_r(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      case (op)
         3'd0:    return a + b;
         3'd1:    return (a >= b) ? (a - b) : '0;
         3'd2:    return p[N-1:0];
         3'd3:    return a & b;
         3'd4:    return a | b;
         default: return '0;
      endcase
   endfunction

   assign bus.ula_r    = alu_r(bus.ula_op, bus.ula_a, bus.ula_b);
   assign bus.ula_zero = (bus.ula_r == '0);

   typedef struct {
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         chain;
   } cmd_t;

   cmd_t         m_q[$];
   logic         m_vld;
   logic [N-1:0] m_r;
   logic         m_zero;
   logic [2:0]   m_op;
   logic [N-1:0] m_acc;

   // Advance one clock and update the reference model with the inputs that edge saw.
   task automatic tick();
      bit           push;
      bit           issue;
      cmd_t         c;
      cmd_t         h;
      logic [N-1:0] ea;
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_vld = 1'b0; m_r = '0; m_zero = 1'b0; m_op = 3'd0; m_acc = '0;
      end else begin
         push  = bus.in_valid && (m_q.size() < DEPTH);
         issue = (m_q.size() != 0) && (!m_vld || bus.out_ready);
         c     = '{bus.in_op, bus.in_a, bus.in_b, bus.in_chain};
         if (issue) begin
            h      = m_q.pop_front();
            ea     = h.chain ? m_acc : h.a;
            m_r    = alu_r(h.op, ea, h.b);
            m_zero = (m_r == '0);
            m_op   = h.op;
            m_acc  = m_r;
            m_vld  = 1'b1;
         end else if (bus.out_ready) begin
            m_vld = 1'b0;
         end
         if (push) m_q.push_back(c);
      end
      @(negedge clk);
   endtask

   task automatic set_cmd(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic ch);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_chain = ch;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      set_cmd(1'b1, 3'd0, 16'd1, 16'd1, 1'b0);
      tick();
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", bus.in_ready); end
      total++; if (bus.acc !== 16'd0) begin bad++; $display("FAIL post_reset_acc got=%0h want=0", bus.acc); end
      total++; if (bus.out_r !== 16'd0) begin bad++; $display("FAIL post_reset_out_r got=%0h want=0", bus.out_r); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_single_add();
      bus.out_ready = 1'b1;
      set_cmd(1'b1, 3'd0, 16'd3, 16'd4, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%0b want=0", bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", bus.out_valid); end
      total++; if (bus.out_r !== 16'd7) begin bad++; $display("FAIL add_r got=%0h want=7", bus.out_r); end
      total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%0b want=0", bus.out_zero); end
      total++; if (bus.out_op !== 3'd0) begin bad++; $display("FAIL add_op got=%0h want=0", bus.out_op); end
      total++; if (bus.acc !== 16'd7) begin bad++; $display("FAIL add_acc got=%0h want=7", bus.acc); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_drain_valid got=%0b want=0", bus.out_valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_drain_busy got=%0b want=0", bus.busy); end
   endtask

   task automatic test_chain();
      bus.out_ready = 1'b1;
      set_cmd(1'b1, 3'd0, 16'd10, 16'd5, 1'b0);
      tick();
      set_cmd(1'b1, 3'd2, 16'd0, 16'd3, 1'b1);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_r !== 16'd15) begin bad++; $display("FAIL chain_r1 got=%0h/%0b want=f/1", bus.out_r, bus.out_valid); end
      set_cmd(1'b1, 3'd1, 16'd0, 16'd45, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_r !== 16'd45) begin bad++; $display("FAIL chain_r2 got=%0h/%0b want=2d/1", bus.out_r, bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_r !== 16'd0) begin bad++; $display("FAIL chain_r3 got=%0h/%0b want=0/1", bus.out_r, bus.out_valid); end
      total++; if (bus.out_zero !== 1'b1) begin bad++; $display("FAIL chain_zero got=%0b want=1", bus.out_zero); end
      total++; if (bus.acc !== 16'd0) begin bad++; $display("FAIL chain_acc got=%0h want=0", bus.acc); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL chain_drain got=%0b want=0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         set_cmd(1'b1, 3'd4, N'(i), 16'd0, 1'b0);
         tick();
      end
      total++; if (bus.out_valid !== 1'b1 || bus.out_r !== 16'd1) begin bad++; $display("FAIL bp_held got=%0h/%0b want=1/1", bus.out_r, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b want=0", bus.in_ready); end
      set_cmd(1'b1, 3'd4, 16'd6, 16'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_r !== 16'd1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stable got=%0h/%0b want=1/0", bus.out_r, bus.in_ready); end
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         total++; if (bus.out_valid !== 1'b1 || bus.out_r !== N'(i)) begin bad++; $display("FAIL bp_seq%0d got=%0h/%0b want=%0h/1", i, bus.out_r, bus.out_valid, i); end
         tick();
         if (i == 1) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%0b want=1", bus.in_ready); end
         end
      end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", bus.out_valid); end
   endtask

   task automatic test_boundaries();
      bus.out_ready = 1'b1;
      set_cmd(1'b1, 3'd1, 16'd5, 16'd9, 1'b0);
      tick();
      set_cmd(1'b1, 3'd7, 16'd7, 16'd7, 1'b0);
      tick();
      total++; if (bus.out_r !== 16'd0 || bus.out_zero !== 1'b1 || bus.out_op !== 3'd1) begin bad++; $display("FAIL bnd_satsub got=%0h/%0b/%0h want=0/1/1", bus.out_r, bus.out_zero, bus.out_op); end
      set_cmd(1'b1, 3'd2, 16'h0100, 16'h0100, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_r !== 16'd0 || bus.out_zero !== 1'b1 || bus.out_op !== 3'd7) begin bad++; $display("FAIL bnd_undef got=%0h/%0b/%0h want=0/1/7", bus.out_r, bus.out_zero, bus.out_op); end
      tick();
      total++; if (bus.out_r !== 16'd0 || bus.out_zero !== 1'b1 || bus.out_op !== 3'd2) begin bad++; $display("FAIL bnd_mul got=%0h/%0b/%0h want=0/1/2", bus.out_r, bus.out_zero, bus.out_op); end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      set_cmd(1'b1, 3'd0, 16'd100, 16'd1, 1'b0);
      tick();
      set_cmd(1'b1, 3'd0, 16'd1, 16'd1, 1'b0);
      tick();
      tick();
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1 || bus.acc !== 16'd101 || bus.busy !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0b/%0h/%0b want=1/65/1", bus.out_valid, bus.acc, bus.busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.acc !== 16'd0) begin bad++; $display("FAIL mid_reset got=%0b/%0b/%0h want=0/0/0", bus.out_valid, bus.busy, bus.acc); end
      bus.out_ready = 1'b1;
      set_cmd(1'b1, 3'd0, 16'd55, 16'd2, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_r !== 16'd2) begin bad++; $display("FAIL mid_chain got=%0h/%0b want=2/1", bus.out_r, bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_drain got=%0b want=0", bus.out_valid); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst           = ($urandom_range(0, 59) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_op     = 3'($urandom_range(0, 7));
         bus.in_a      = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
         bus.in_b      = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
         bus.in_chain  = ($urandom_range(0, 2) == 0);
         tick();
         total++; if (bus.out_valid !== m_vld) begin bad++; $display("FAIL rnd_valid c%0d got=%0b want=%0b", cyc, bus.out_valid, m_vld); end
         if (m_vld) begin
            total++; if (bus.out_r !== m_r || bus.out_zero !== m_zero || bus.out_op !== m_op) begin bad++; $display("FAIL rnd_result c%0d got=%0h/%0b/%0h want=%0h/%0b/%0h", cyc, bus.out_r, bus.out_zero, bus.out_op, m_r, m_zero, m_op); end
         end
         total++; if (bus.acc !== m_acc) begin bad++; $display("FAIL rnd_acc c%0d got=%0h want=%0h", cyc, bus.acc, m_acc); end
         total++; if (bus.busy !== ((m_q.size() != 0) || m_vld)) begin bad++; $display("FAIL rnd_busy c%0d got=%0b want=%0b", cyc, bus.busy, (m_q.size() != 0) || m_vld); end
         total++; if (bus.in_ready !== (!rst && (m_q.size() < DEPTH))) begin bad++; $display("FAIL rnd_in_ready c%0d got=%0b want=%0b", cyc, bus.in_ready, !rst && (m_q.size() < DEPTH)); end
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      set_cmd(1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
      m_vld = 1'b0; m_r = '0; m_zero = 1'b0; m_op = 3'd0; m_acc = '0;
      @(negedge clk);
      test_reset();
      test_single_add();
      test_chain();
      test_backpressure();
      test_boundaries();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
